// File: rtl/stoch_sched_pkg.sv
// Shared types and helpers for the stochastic-stream schedulers.
// Holds the round-robin pointer step and the channel-index width derivation.
package stoch_sched_pkg;

  localparam int COUNTER_ONE = 1;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_op_e;

  function automatic int ch_width(input int n_ch);
    return (n_ch < 2) ? 1 : $clog2(n_ch);
  endfunction

  // Next round-robin position after index k, wrapping modulo n_ch.
  function automatic int rr_next(input int k, input int n_ch);
    return (k + 1 >= n_ch) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/stoch_sat_sub_step.sv
// Combinational max(a - b, 0) update step for one stochastic channel.
// Maps (residue, a, b) to the next residue and the emitted stream bit.
module stoch_sat_sub_step
  import stoch_sched_pkg::*;
#(
  parameter int COUNTER_SIZE = 8
) (
  input  logic [COUNTER_SIZE-1:0] i_cnt,
  input  logic                    i_a,
  input  logic                    i_b,
  output logic [COUNTER_SIZE-1:0] o_cnt_next,
  output logic                    o_y_next
);

  localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(COUNTER_ONE);

  step_op_e                w_op;
  logic [COUNTER_SIZE-1:0] w_cu;

  always_comb begin
    w_op = STEP_HOLD;
    if (i_a && !i_b) begin
      w_op = STEP_INC;
    end else if (i_b && !i_a) begin
      w_op = STEP_DEC;
    end
  end

  // Increment saturates at all-ones and decrement floors at zero, so the residue never wraps.
  always_comb begin
    w_cu = i_cnt;
    case (w_op)
      STEP_INC: begin
        if (!(&i_cnt)) begin
          w_cu = i_cnt + ONE;
        end
      end
      STEP_DEC: begin
        if (i_cnt != '0) begin
          w_cu = i_cnt - ONE;
        end
      end
      default: w_cu = i_cnt;
    endcase
  end

  always_comb begin
    o_y_next   = (w_cu != '0);
    o_cnt_next = o_y_next ? (w_cu - ONE) : '0;
  end

endmodule

// File: rtl/stoch_sat_sub_sched.sv
// Round-robin scheduler sharing one saturating-subtract step across N_CH stochastic channels.
// Per-channel residue and bit-position counters live in a small state file here.
module stoch_sat_sub_sched
  import stoch_sched_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int COUNTER_SIZE = 8,
  parameter  int LEN_SIZE     = 10,
  localparam int CH_W         = ch_width(N_CH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_CH-1:0]     req,
  input  logic [N_CH-1:0]     a,
  input  logic [N_CH-1:0]     b,
  input  logic [N_CH-1:0]     clr,
  input  logic [LEN_SIZE-1:0] len,
  output logic [N_CH-1:0]     gnt,
  output logic                y_valid,
  output logic                y,
  output logic [CH_W-1:0]     y_ch,
  output logic                y_last
);

  logic [COUNTER_SIZE-1:0] r_cnt    [N_CH];
  logic [LEN_SIZE-1:0]     r_bitcnt [N_CH];
  logic [CH_W-1:0]         r_ptr;

  logic [N_CH-1:0]         w_elig;
  logic                    w_gnt_any;
  logic [CH_W-1:0]         w_gnt_idx;
  logic [CH_W-1:0]         w_ptr_next;
  int                      w_scan;

  logic [COUNTER_SIZE-1:0] w_sel_cnt;
  logic [COUNTER_SIZE-1:0] w_step_cnt;
  logic [COUNTER_SIZE-1:0] w_cnt_upd;
  logic [LEN_SIZE-1:0]     w_sel_bitcnt;
  logic [LEN_SIZE-1:0]     w_bitcnt_upd;
  logic                    w_sel_a;
  logic                    w_sel_b;
  logic                    w_y_next;
  logic                    w_is_last;

  // A clear on a channel suppresses its request so the pending pair stays unconsumed.
  always_comb begin
    w_elig     = RST ? '0 : (req & ~clr);
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    gnt        = '0;
    w_scan     = int'(r_ptr);
    for (int n = 0; n < N_CH; n++) begin
      if (!w_gnt_any && w_elig[CH_W'(w_scan)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = CH_W'(w_scan);
      end
      w_scan = rr_next(w_scan, N_CH);
    end
    if (w_gnt_any) begin
      gnt[w_gnt_idx] = 1'b1;
    end
    w_ptr_next = CH_W'(rr_next(int'(w_gnt_idx), N_CH));
  end

  always_comb begin
    w_sel_cnt    = r_cnt[w_gnt_idx];
    w_sel_bitcnt = r_bitcnt[w_gnt_idx];
    w_sel_a      = a[w_gnt_idx];
    w_sel_b      = b[w_gnt_idx];
  end

  stoch_sat_sub_step #(
    .COUNTER_SIZE (COUNTER_SIZE)
  ) u_step (
    .i_cnt      (w_sel_cnt),
    .i_a        (w_sel_a),
    .i_b        (w_sel_b),
    .o_cnt_next (w_step_cnt),
    .o_y_next   (w_y_next)
  );

  // A bit counter already at or past len-1 (len shrunk mid-stream) also ends the stream.
  always_comb begin
    w_is_last    = (len != '0) && (w_sel_bitcnt >= (len - LEN_SIZE'(1)));
    w_cnt_upd    = w_is_last ? '0 : w_step_cnt;
    w_bitcnt_upd = '0;
    if (!w_is_last) begin
      w_bitcnt_upd = (&w_sel_bitcnt) ? w_sel_bitcnt : (w_sel_bitcnt + LEN_SIZE'(1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]    <= '0;
        r_bitcnt[i] <= '0;
      end
      r_ptr   <= '0;
      y_valid <= 1'b0;
      y       <= 1'b0;
      y_ch    <= '0;
      y_last  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) begin
          r_cnt[i]    <= '0;
          r_bitcnt[i] <= '0;
        end else if (w_gnt_any && (w_gnt_idx == CH_W'(i))) begin
          r_cnt[i]    <= w_cnt_upd;
          r_bitcnt[i] <= w_bitcnt_upd;
        end
      end
      if (w_gnt_any) begin
        r_ptr <= w_ptr_next;
        y_ch  <= w_gnt_idx;
      end
      y_valid <= w_gnt_any;
      y       <= w_gnt_any & w_y_next;
      y_last  <= w_gnt_any & w_is_last;
    end
  end

endmodule

// File: tb/tb_stoch_sat_sub_sched.sv
// Directed-vector bench for stoch_sat_sub_sched; expected outputs are queued at grant time
// and a separate negedge monitor pops and compares them whenever y_valid is high.
module tb_stoch_sat_sub_sched;

  localparam int N_CH         = 4;
  localparam int COUNTER_SIZE = 3;
  localparam int LEN_SIZE     = 10;
  localparam int CH_W         = 2;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N_CH-1:0]     req;
  logic [N_CH-1:0]     a;
  logic [N_CH-1:0]     b;
  logic [N_CH-1:0]     clr;
  logic [LEN_SIZE-1:0] len;
  logic [N_CH-1:0]     gnt;
  logic                y_valid;
  logic                y;
  logic [CH_W-1:0]     y_ch;
  logic                y_last;

  typedef struct packed {
    logic            y;
    logic [CH_W-1:0] ch;
    logic            last;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 CLK = ~CLK;

  stoch_sat_sub_sched #(
    .N_CH         (N_CH),
    .COUNTER_SIZE (COUNTER_SIZE),
    .LEN_SIZE     (LEN_SIZE)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req),
    .a       (a),
    .b       (b),
    .clr     (clr),
    .len     (len),
    .gnt     (gnt),
    .y_valid (y_valid),
    .y       (y),
    .y_ch    (y_ch),
    .y_last  (y_last)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational grant, queues the expected result.
  task automatic applyStimulus(input string name, input logic [N_CH-1:0] rq, input logic [N_CH-1:0] av,
                               input logic [N_CH-1:0] bv, input logic [N_CH-1:0] cl,
                               input logic [LEN_SIZE-1:0] ln, input logic [N_CH-1:0] expGnt,
                               input logic expY, input logic expLast);
    exp_t e;
    req = rq;
    a   = av;
    b   = bv;
    clr = cl;
    len = ln;
    #1;
    checkOutput({name, "_gnt"}, 32'(gnt), 32'(expGnt));
    if (expGnt != '0) begin
      e.y    = expY;
      e.ch   = '0;
      e.last = expLast;
      for (int i = 0; i < N_CH; i++) begin
        if (expGnt[i]) e.ch = CH_W'(i);
      end
      expQ.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (y_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_valid: got y_valid=1 ch=%0d, expected no output at %0t", y_ch, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_y", 32'(y), 32'(e.y));
          checkOutput("out_ch", 32'(y_ch), 32'(e.ch));
          checkOutput("out_last", 32'(y_last), 32'(e.last));
        end
      end
    end
  end

  initial begin : stimulus
    RST = 1'b1;
    req = '1;
    a   = '0;
    b   = '0;
    clr = '0;
    len = '0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_valid", 32'(y_valid), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_ych", 32'(y_ch), 32'd0);
    checkOutput("rst_last", 32'(y_last), 32'd0);
    RST = 1'b0;

    $display("[TB] round-robin rotation, a=b=1");
    for (int i = 0; i < 5; i++) begin
      applyStimulus("rotate", 4'b1111, 4'b1111, 4'b1111, 4'b0000, 10'd0,
                    4'(4'b0001 << (i % 4)), 1'b0, 1'b0);
    end

    $display("[TB] single channel inc then dec");
    for (int i = 0; i < 6; i++) begin
      applyStimulus("single", 4'b0001, (i < 3) ? 4'b0001 : 4'b0000, (i < 3) ? 4'b0000 : 4'b0001,
                    4'b0000, 10'd0, 4'b0001, (i < 3), 1'b0);
    end

    $display("[TB] len=4 streams on channel 2");
    applyStimulus("clr2", 4'b0000, 4'b0000, 4'b0000, 4'b0100, 10'd4, 4'b0000, 1'b0, 1'b0);
    checkOutput("clr2_valid", 32'(y_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("len4", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 10'd4, 4'b0100, 1'b1, ((i % 4) == 3));
    end

    $display("[TB] len shrinks below channel 0 bit position");
    applyStimulus("lenshrink", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 10'd4, 4'b0001, 1'b1, 1'b1);
    applyStimulus("lenshrink2", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 10'd4, 4'b0001, 1'b1, 1'b0);

    $display("[TB] saturation run on channel 1");
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat_inc", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 10'd0, 4'b0010, 1'b1, 1'b0);
    end
    applyStimulus("sat_dec", 4'b0010, 4'b0000, 4'b0010, 4'b0000, 10'd0, 4'b0010, 1'b0, 1'b0);

    $display("[TB] clr beats req on channel 3");
    applyStimulus("clr3", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 10'd2, 4'b0000, 1'b0, 1'b0);
    checkOutput("clr3_valid", 32'(y_valid), 32'd0);
    applyStimulus("clr3_g1", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 10'd2, 4'b1000, 1'b1, 1'b0);
    applyStimulus("clr3_g2", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 10'd2, 4'b1000, 1'b1, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus("pre_rst", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 10'd0, 4'b0001, 1'b1, 1'b0);
    applyStimulus("pre_rst", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 10'd0, 4'b0010, 1'b1, 1'b0);
    RST = 1'b1;
    applyStimulus("mid_rst", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 10'd0, 4'b0000, 1'b0, 1'b0);
    RST = 1'b0;
    checkOutput("mid_rst_valid", 32'(y_valid), 32'd0);
    checkOutput("mid_rst_y", 32'(y), 32'd0);
    checkOutput("mid_rst_ych", 32'(y_ch), 32'd0);
    checkOutput("mid_rst_last", 32'(y_last), 32'd0);
    applyStimulus("post_rst", 4'b0110, 4'b0110, 4'b0000, 4'b0000, 10'd0, 4'b0010, 1'b1, 1'b0);
    applyStimulus("post_rst", 4'b0110, 4'b0110, 4'b0000, 4'b0000, 10'd0, 4'b0100, 1'b1, 1'b0);

    applyStimulus("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
